alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 clk  input  1  rising-edge clock; sole clock domain.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 in_valid  input  1  upstream offers an instruction this cycle.
REQ-004 in_ready  output  1  stage accepts the offer this cycle.
REQ-005 inst  input  32  RV32I instruction word.
REQ-006 pc  input  32  address of inst.
REQ-007 rs1_val  input  32  register-file value for inst[19:15].
REQ-008 rs2_val  input  32  register-file value for inst[24:20].
REQ-009 flush  input  1  discard held entry and any offer this cycle.
REQ-010 out_valid  output  1  decoded entry present.
REQ-011 out_ready  input  1  downstream (ALU/writeback) consumes entry.
REQ-012 s1  output  32  ALU operand 1.
REQ-013 s2  output  32  ALU operand 2.
REQ-014 op  output  4  ALU op code {funct7[5],funct3}: 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT, 0011 SLTU, 0100 XOR, 0101 SRL, 1101 SRA, 0110 OR, 0111 AND.
REQ-015 rd  output  5  destination register.
REQ-016 we  output  1  write-back enable.
REQ-017 illegal  output  1  entry is an unsupported or malformed instruction.
REQ-018 issue_count  output  32  count of entries consumed downstream.

Function
REQ-019 Stage SHALL be one output register; accept when in_valid && in_ready; in_ready = !out_valid || out_ready; latency exactly one cycle from accept to out_valid.
REQ-020 All outputs except in_ready/issue_count SHALL hold stable while out_valid && !out_ready.
REQ-021 Consume when out_valid && out_ready; consume and accept in same cycle SHALL replace entry with no bubble.
REQ-022 OP (opcode 0110011): s1=rs1_val, s2=rs2_val, op={inst[30],funct3}; legal only if inst[31:25]=0000000, or 0100000 with funct3 000/101.
REQ-023 OP-IMM (0010011): s1=rs1_val, s2=sign-extended inst[31:20], op={0,funct3}; funct3=001 legal only with inst[31:25]=0; funct3=101 legal only with inst[31:25] 0000000/0100000, op={inst[30],101}.
REQ-024 Shift ops (op[2:0]=001/101) SHALL drive s2={27'b0, shamt[4:0]}: shamt=inst[24:20] for OP-IMM, rs2_val[4:0] for OP.
REQ-025 rd=inst[11:7]; we=1 only when legal and rd!=0.
REQ-026 Illegal entry: illegal=1, we=0, op=0000, s1=s2=0, rd=inst[11:7]; entry still flows through handshake.
REQ-027 flush SHALL clear out_valid next cycle and drop any same-cycle offer; flush with out_ready does not increment issue_count.
REQ-028 issue_count SHALL increment by 1 per consume (REQ-021), wrapping 0xFFFFFFFF->0, illegal entries included.

Reset
REQ-029 rst SHALL, on the clock edge, set out_valid=0, s1=s2=0, op=0, rd=0, we=0, illegal=0, issue_count=0; rst overrides flush and any handshake.
REQ-030 During rst in_ready SHALL be 0; first accept possible the cycle after rst deasserts.

Configuration
REQ-031 With ALU_ISSUE_UPPER_EN defined: LUI (0110111) s1=0, s2={inst[31:12],12'b0}, op=ADD; AUIPC (0010111) s1=pc, s2 same, op=ADD; both legal per REQ-025.
REQ-032 Without ALU_ISSUE_UPPER_EN: LUI/AUIPC SHALL be illegal per REQ-026; pc unused.

Verification
REQ-033 Accept inst 0x00208033 (add x0? no: rd=0) with rs1_val=5, rs2_val=7 -> next cycle out_valid=1, op=0000, s1=5, s2=7, we=0.
REQ-034 inst 0x40315093 (srai x1,x2,3), rs1_val=0x80000000 -> op=1101, s2=3, rd=1, we=1, illegal=0.
REQ-035 OP sll with rs2_val=0xFFFFFF21 -> s2=0x00000001; inst with opcode 0000011 -> illegal=1, we=0, op=0.
REQ-036 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs frozen; out_ready=1 -> consume+accept same cycle, issue_count +1.
REQ-037 flush with out_valid=1 and in_valid=1 -> out_valid=0 next cycle, issue_count unchanged; rst mid-stall -> all outputs zero next cycle.
REQ-038 LUI 0x123450B7 -> with macro s2=0x12345000, s1=0, op=0000; without macro illegal=1.

Source files
------------

// File: rtl/alu_issue.sv
// RV32I ALU issue stage: decodes OP/OP-IMM into operands and a 4-bit ALU op behind a single
// output register with valid/ready handshake. Define ALU_ISSUE_UPPER_EN to also issue LUI/AUIPC.
module alu_issue (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_rs1_val,
  input  logic [31:0] i_rs2_val,
  input  logic        i_flush,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [31:0] o_s1,
  output logic [31:0] o_s2,
  output logic [3:0]  o_op,
  output logic [4:0]  o_rd,
  output logic        o_we,
  output logic        o_illegal,
  output logic [31:0] o_issue_count
);

  localparam logic [6:0] OpcOp    = 7'b0110011;
  localparam logic [6:0] OpcOpImm = 7'b0010011;
  localparam logic [6:0] F7Alt    = 7'b0100000;

  logic [6:0]  w_opcode;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic        w_shift;
  logic        w_ill;
  logic [31:0] w_s1;
  logic [31:0] w_s2;
  logic [3:0]  w_op;
  logic        w_we;
  logic        w_accept;
  logic        w_consume;

  logic        r_valid;
  logic [31:0] r_s1;
  logic [31:0] r_s2;
  logic [3:0]  r_op;
  logic [4:0]  r_rd;
  logic        r_we;
  logic        r_ill;
  logic [31:0] r_cnt;

  assign w_opcode = i_inst[6:0];
  assign w_f3     = i_inst[14:12];
  assign w_f7     = i_inst[31:25];
  assign w_shift  = (w_f3[1:0] == 2'b01);

`ifdef ALU_ISSUE_UPPER_EN
  logic w_unused_bits;
  assign w_unused_bits = ^i_inst[19:15];
`else
  logic w_unused_bits;
  assign w_unused_bits = ^{i_pc, i_inst[19:15]};
`endif

  always_comb begin
    w_ill = 1'b1;
    w_s1  = '0;
    w_s2  = '0;
    w_op  = '0;
    case (w_opcode)
      OpcOp: begin
        if (w_f7 == 7'd0 || (w_f7 == F7Alt && (w_f3 == 3'b000 || w_f3 == 3'b101))) begin
          w_ill = 1'b0;
          w_s1  = i_rs1_val;
          w_op  = {i_inst[30], w_f3};
          w_s2  = w_shift ? {27'd0, i_rs2_val[4:0]} : i_rs2_val;
        end
      end
      OpcOpImm: begin
        if (!((w_f3 == 3'b001 && w_f7 != 7'd0) ||
              (w_f3 == 3'b101 && w_f7 != 7'd0 && w_f7 != F7Alt))) begin
          w_ill = 1'b0;
          w_s1  = i_rs1_val;
          // Only SRAI carries inst[30] into the op; other immediates use it as data.
          w_op  = {(w_f3 == 3'b101) & i_inst[30], w_f3};
          w_s2  = w_shift ? {27'd0, i_inst[24:20]} : {{20{i_inst[31]}}, i_inst[31:20]};
        end
      end
`ifdef ALU_ISSUE_UPPER_EN
      7'b0110111: begin
        w_ill = 1'b0;
        w_s2  = {i_inst[31:12], 12'd0};
      end
      7'b0010111: begin
        w_ill = 1'b0;
        w_s1  = i_pc;
        w_s2  = {i_inst[31:12], 12'd0};
      end
`endif
      default: ;
    endcase
  end

  assign w_we       = !w_ill && (i_inst[11:7] != 5'd0);
  assign o_in_ready = !i_rst && (!r_valid || i_out_ready);
  // Flush wins over both the incoming offer and the downstream consume.
  assign w_accept   = i_in_valid && o_in_ready && !i_flush;
  assign w_consume  = r_valid && i_out_ready && !i_flush;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_s1    <= '0;
      r_s2    <= '0;
      r_op    <= '0;
      r_rd    <= '0;
      r_we    <= 1'b0;
      r_ill   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (i_flush) begin
        r_valid <= 1'b0;
      end else if (w_accept) begin
        r_valid <= 1'b1;
        r_s1    <= w_s1;
        r_s2    <= w_s2;
        r_op    <= w_op;
        r_rd    <= i_inst[11:7];
        r_we    <= w_we;
        r_ill   <= w_ill;
      end else if (w_consume) begin
        r_valid <= 1'b0;
      end
      if (w_consume) begin
        r_cnt <= r_cnt + 32'd1;
      end
    end
  end

  assign o_out_valid   = r_valid;
  assign o_s1          = r_s1;
  assign o_s2          = r_s2;
  assign o_op          = r_op;
  assign o_rd          = r_rd;
  assign o_we          = r_we;
  assign o_illegal     = r_ill;
  assign o_issue_count = r_cnt;

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: directed scenarios plus randomized traffic against a
// mnemonic-level reference decoder.
module tb_alu_issue;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] s1;
  logic [31:0] s2;
  logic [3:0]  op;
  logic [4:0]  rd;
  logic        we;
  logic        illegal;
  logic [31:0] issue_count;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] s1;
    logic [31:0] s2;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] exp_cnt;

  alu_issue dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_in_valid    (in_valid),
    .o_in_ready    (in_ready),
    .i_inst        (inst),
    .i_pc          (pc),
    .i_rs1_val     (rs1_val),
    .i_rs2_val     (rs2_val),
    .i_flush       (flush),
    .o_out_valid   (out_valid),
    .i_out_ready   (out_ready),
    .o_s1          (s1),
    .o_s2          (s2),
    .o_op          (op),
    .o_rd          (rd),
    .o_we          (we),
    .o_illegal     (illegal),
    .o_issue_count (issue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decoder: classify the instruction by mnemonic, then build the operands.
  function automatic exp_t model(input logic [31:0] in, input logic [31:0] p,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] imm;
    f7    = in[31:25];
    f3    = in[14:12];
    imm   = 32'($signed(in[31:20]));
    e     = '0;
    e.rd  = in[11:7];
    e.ill = 1'b1;
    if (in[6:0] == 7'h33) begin
      if (f7 == 7'h00) begin
        e.ill = 1'b0; e.s1 = a; e.op = {1'b0, f3};
        e.s2 = (f3 == 3'd1 || f3 == 3'd5) ? (b % 32) : b;
      end else if (f7 == 7'h20 && f3 == 3'd0) begin
        e.ill = 1'b0; e.s1 = a; e.op = 4'b1000; e.s2 = b;
      end else if (f7 == 7'h20 && f3 == 3'd5) begin
        e.ill = 1'b0; e.s1 = a; e.op = 4'b1101; e.s2 = b % 32;
      end
    end else if (in[6:0] == 7'h13) begin
      if (f3 == 3'd1) begin
        if (f7 == 7'h00) begin
          e.ill = 1'b0; e.s1 = a; e.op = 4'b0001; e.s2 = 32'(in[24:20]);
        end
      end else if (f3 == 3'd5) begin
        if (f7 == 7'h00) begin
          e.ill = 1'b0; e.s1 = a; e.op = 4'b0101; e.s2 = 32'(in[24:20]);
        end else if (f7 == 7'h20) begin
          e.ill = 1'b0; e.s1 = a; e.op = 4'b1101; e.s2 = 32'(in[24:20]);
        end
      end else begin
        e.ill = 1'b0; e.s1 = a; e.op = {1'b0, f3}; e.s2 = imm;
      end
    end
`ifdef ALU_ISSUE_UPPER_EN
    else if (in[6:0] == 7'h37 || in[6:0] == 7'h17) begin
      e.ill = 1'b0;
      e.s1  = (in[6:0] == 7'h17) ? p : 32'd0;
      e.s2  = in & 32'hFFFF_F000;
    end
`endif
    e.we = !e.ill && e.rd != 5'd0;
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [6:0] opc;
    logic [6:0] f7;
    case ($urandom_range(0, 9))
      0, 1, 2, 3: opc = 7'h33;
      4, 5, 6:    opc = 7'h13;
      7:          opc = 7'h37;
      8:          opc = 7'h17;
      default:    opc = 7'($urandom);
    endcase
    case ($urandom_range(0, 3))
      0, 1:    f7 = 7'h00;
      2:       f7 = 7'h20;
      default: f7 = 7'($urandom);
    endcase
    return {f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), opc};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, req);
    end
  endtask

  // Monitor: predict accepts, compare the held entry, retire on consume or flush.
  always @(negedge clk) begin
    exp_t act;
    if (rst) begin
      sb_q.delete();
      exp_cnt = 32'd0;
    end else begin
      chk("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
      chk("issue_count", issue_count, exp_cnt);
      if (out_valid) begin
        total++;
        act = '{s1: s1, s2: s2, op: op, rd: rd, we: we, ill: illegal};
        if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL entry: got out_valid with empty scoreboard");
        end else begin
          if (act !== sb_q[0]) begin
            bad++;
            $display("FAIL entry: got s1=%h s2=%h op=%h rd=%0d we=%b ill=%b want s1=%h s2=%h op=%h rd=%0d we=%b ill=%b",
                     act.s1, act.s2, act.op, act.rd, act.we, act.ill, sb_q[0].s1, sb_q[0].s2,
                     sb_q[0].op, sb_q[0].rd, sb_q[0].we, sb_q[0].ill);
          end
          if (flush || out_ready) begin
            if (!flush) exp_cnt = exp_cnt + 32'd1;
            void'(sb_q.pop_front());
          end
        end
      end
      if (in_valid && in_ready && !flush) sb_q.push_back(model(inst, pc, rs1_val, rs2_val));
    end
  end

  task automatic issue1(input logic [31:0] i, input logic [31:0] p, input logic [31:0] a,
                        input logic [31:0] b);
    @(posedge clk); #1;
    in_valid = 1'b1; inst = i; pc = p; rs1_val = a; rs2_val = b; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] sll_inst;
    rst = 1'b1; in_valid = 1'b0; inst = '0; pc = '0; rs1_val = '0; rs2_val = '0;
    flush = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_s1", s1, 32'd0);
    chk("rst_count", issue_count, 32'd0);

    // add x0,x1,x2
    issue1(32'h0020_8033, 32'h0, 32'd5, 32'd7);
    @(negedge clk);
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_op", 32'(op), 32'h0);
    chk("add_s1", s1, 32'd5);
    chk("add_s2", s2, 32'd7);
    chk("add_we", 32'(we), 32'd0);

    // Stall with srai offered, then consume+accept in one edge.
    in_valid = 1'b1; inst = 32'h4031_5093; rs1_val = 32'h8000_0000; rs2_val = 32'h0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_s1", s1, 32'd5);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("swap_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("swap_count", issue_count, 32'd1);
    chk("srai_valid", 32'(out_valid), 32'd1);
    chk("srai_op", 32'(op), 32'hD);
    chk("srai_s2", s2, 32'd3);
    chk("srai_rd", 32'(rd), 32'd1);
    chk("srai_we", 32'(we), 32'd1);
    chk("srai_ill", 32'(illegal), 32'd0);
    drain();

    sll_inst = {7'h00, 5'd3, 5'd2, 3'b001, 5'd4, 7'h33};
    issue1(sll_inst, 32'h0, 32'h1234_5678, 32'hFFFF_FF21);
    @(negedge clk);
    chk("sll_s2", s2, 32'h1);
    chk("sll_op", 32'(op), 32'h1);
    drain();

    issue1(32'h0001_2083, 32'h0, 32'h11, 32'h22);
    @(negedge clk);
    chk("lw_ill", 32'(illegal), 32'd1);
    chk("lw_we", 32'(we), 32'd0);
    chk("lw_op", 32'(op), 32'h0);
    chk("lw_rd", 32'(rd), 32'd1);
    drain();
    @(negedge clk);
    chk("drain_count", issue_count, 32'd4);

    // Flush with entry held, offer present and downstream ready.
    issue1(32'h0020_8033, 32'h0, 32'd1, 32'd2);
    in_valid = 1'b1; flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_count", issue_count, 32'd4);

    // Reset in the middle of a stall.
    issue1(32'h4031_5093, 32'h0, 32'hDEAD_BEEF, 32'h0);
    in_valid = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_s1", s1, 32'd0);
    chk("mrst_s2", s2, 32'd0);
    chk("mrst_op_rd_we_ill", {23'd0, op, rd}, {31'd0, we | illegal});
    chk("mrst_count", issue_count, 32'd0);

    issue1(32'h1234_50B7, 32'h0000_4000, 32'h99, 32'h77);
    @(negedge clk);
`ifdef ALU_ISSUE_UPPER_EN
    chk("lui_s2", s2, 32'h1234_5000);
    chk("lui_s1", s1, 32'd0);
    chk("lui_op", 32'(op), 32'h0);
    chk("lui_we", 32'(we), 32'd1);
`else
    chk("lui_ill", 32'(illegal), 32'd1);
    chk("lui_s2", s2, 32'd0);
`endif
    drain();

    for (int n = 0; n < 600; n++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      inst      = rand_inst();
      pc        = $urandom;
      rs1_val   = $urandom;
      rs2_val   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FF21 : $urandom;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0; rst = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
